// File: rtl/dct2d_strip_arbiter_if.sv
// -----------------------------------------------------------------------------
// dct2d_strip_arbiter_if
// Purpose : bundles every handshake/data signal around the Dct2D strip arbiter:
//           two raster sources (s0_*, s1_*), the Dct2D input side (dct_*_o,
//           dct_ready_i), the Dct2D output side (dct_*_i, dct_ready_o), the
//           labelled coefficient sink (m_*) and the sticky error flags (err_o).
//           Signal suffixes are written from the arbiter's point of view.
// Modports: slave  - the arbiter
//           master - everything around it (sources, Dct2D, sink)
// -----------------------------------------------------------------------------
interface dct2d_strip_arbiter_if #(
   parameter int DinWidth  = 8,
   parameter int DoutWidth = 16
);
   // channel 0 source
   logic                      s0_valid_i;
   logic                      s0_ready_o;
   logic                      s0_eol_i;
   logic                      s0_sof_i;
   logic [0:7][DinWidth-1:0]  s0_data_i;
   // channel 1 source
   logic                      s1_valid_i;
   logic                      s1_ready_o;
   logic                      s1_eol_i;
   logic                      s1_sof_i;
   logic [0:7][DinWidth-1:0]  s1_data_i;
   // towards Dct2D
   logic                      dct_valid_o;
   logic                      dct_ready_i;
   logic                      dct_eol_o;
   logic                      dct_sof_o;
   logic [0:7][DinWidth-1:0]  dct_data_o;
   // from Dct2D
   logic                      dct_valid_i;
   logic                      dct_ready_o;
   logic                      dct_eol_i;
   logic                      dct_sof_i;
   logic [0:7][DoutWidth-1:0] dct_data_i;
   // labelled coefficient sink
   logic                      m_valid_o;
   logic                      m_ready_i;
   logic                      m_eol_o;
   logic                      m_sof_o;
   logic                      m_chan_o;
   logic [0:7][DoutWidth-1:0] m_data_o;
   logic [2:0]                err_o;

   modport slave (
      input  s0_valid_i, s0_eol_i, s0_sof_i, s0_data_i,
      output s0_ready_o,
      input  s1_valid_i, s1_eol_i, s1_sof_i, s1_data_i,
      output s1_ready_o,
      output dct_valid_o, dct_eol_o, dct_sof_o, dct_data_o,
      input  dct_ready_i,
      input  dct_valid_i, dct_eol_i, dct_sof_i, dct_data_i,
      output dct_ready_o,
      output m_valid_o, m_eol_o, m_sof_o, m_chan_o, m_data_o,
      input  m_ready_i,
      output err_o
   );

   modport master (
      output s0_valid_i, s0_eol_i, s0_sof_i, s0_data_i,
      input  s0_ready_o,
      output s1_valid_i, s1_eol_i, s1_sof_i, s1_data_i,
      input  s1_ready_o,
      input  dct_valid_o, dct_eol_o, dct_sof_o, dct_data_o,
      output dct_ready_i,
      output dct_valid_i, dct_eol_i, dct_sof_i, dct_data_i,
      input  dct_ready_o,
      input  m_valid_o, m_eol_o, m_sof_o, m_chan_o, m_data_o,
      output m_ready_i,
      input  err_o
   );
endinterface

// File: rtl/dct2d_strip_arbiter.sv
// -----------------------------------------------------------------------------
// dct2d_strip_arbiter
// Purpose : shares one Dct2D core between two raster sources at strip
//           granularity (8 eol-terminated lines). A whole strip is granted to
//           one channel by round robin and its beats are muxed into the core
//           with zero latency. The owning channel of every in-flight strip is
//           kept in a small tag FIFO and used to label the core's output beats.
// Ports   : clk_i  - clock
//           rst_i  - asynchronous active-high reset (Dct2D is reset with it)
//           bus    - dct2d_strip_arbiter_if.slave (sources, Dct2D in/out,
//                    sink, err_o)
// Params  : DinWidth (pixel lane bits), DoutWidth (coefficient lane bits),
//           TagDepth (max strips in flight, power of 2, >=2)
// Options : DCT_ARB_ERR_EN - when defined, err_o carries sticky protocol
//           checkers: [0]/[1] source sof on a non-first strip beat,
//           [2] Dct2D output valid while no strip is in flight.
//           When undefined err_o is tied to zero.
// -----------------------------------------------------------------------------
module dct2d_strip_arbiter #(
   parameter int DinWidth  = 8,
   parameter int DoutWidth = 16,
   parameter int TagDepth  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   dct2d_strip_arbiter_if.slave  bus
);
   localparam int AW = $clog2(TagDepth);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                   state_q, state_d;
   logic                     grant_q, grant_d;   // channel owning current strip
   logic                     last_q, last_d;     // channel of last finished strip
   logic                     first_q, first_d;   // next handshake is strip beat 0
   logic [2:0]               line_q, line_d;     // input eol count in strip
   logic [2:0]               oeol_q, oeol_d;     // output eol count in strip
   logic [AW:0]              wptr_q, wptr_d;
   logic [AW:0]              rptr_q, rptr_d;
   logic [TagDepth-1:0]      tag_q;              // one channel bit per slot

   logic                     push, pop, fifo_empty, fifo_full;
   logic                     sel_valid, sel_eol, in_hs, out_hs, granted;
   logic [0:7][DinWidth-1:0] sel_data;

   // extra pointer MSB distinguishes full from empty
   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // ---------------- input side: source mux ----------------
   always_comb begin
      sel_valid = bus.s0_valid_i;
      sel_eol   = bus.s0_eol_i;
      sel_data  = bus.s0_data_i;
      if (grant_q) begin
         sel_valid = bus.s1_valid_i;
         sel_eol   = bus.s1_eol_i;
         sel_data  = bus.s1_data_i;
      end
   end

   assign granted         = (state_q == GRANT);
   assign bus.dct_valid_o = granted & sel_valid;
   assign bus.dct_eol_o   = sel_eol;
   assign bus.dct_data_o  = sel_data;
   // strip framing is regenerated here; source sof is not forwarded
   assign bus.dct_sof_o   = granted & first_q;
   assign bus.s0_ready_o  = granted & ~grant_q & bus.dct_ready_i;
   assign bus.s1_ready_o  = granted &  grant_q & bus.dct_ready_i;
   assign in_hs           = bus.dct_valid_o & bus.dct_ready_i;

   // ---------------- strip FSM ----------------
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      first_d = first_q;
      line_d  = line_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_full && (bus.s0_valid_i || bus.s1_valid_i)) begin
               // both requesting: alternate; otherwise the lone requester
               grant_d = (bus.s0_valid_i && bus.s1_valid_i) ? ~last_q : bus.s1_valid_i;
               push    = 1'b1;
               first_d = 1'b1;
               line_d  = 3'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (in_hs) begin
               first_d = 1'b0;
               if (sel_eol) begin
                  line_d = line_q + 3'd1;
                  if (line_q == 3'd7) begin
                     // returning to IDLE leaves the required bubble cycle
                     state_d = IDLE;
                     last_d  = grant_q;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output side: labelling ----------------
   // core output is held off (not dropped) while no strip is in flight
   assign bus.m_valid_o   = bus.dct_valid_i & ~fifo_empty;
   assign bus.dct_ready_o = bus.m_ready_i   & ~fifo_empty;
   assign bus.m_eol_o     = bus.dct_eol_i;
   assign bus.m_sof_o     = bus.dct_sof_i;
   assign bus.m_data_o    = bus.dct_data_i;
   assign bus.m_chan_o    = tag_q[rptr_q[AW-1:0]];
   assign out_hs          = bus.m_valid_o & bus.m_ready_i;

   always_comb begin
      oeol_d = oeol_q;
      pop    = 1'b0;
      if (out_hs && bus.dct_eol_i) begin
         oeol_d = oeol_q + 3'd1;
         pop    = (oeol_q == 3'd7);
      end
   end

   assign wptr_d = wptr_q + (AW+1)'(push);
   assign rptr_d = rptr_q + (AW+1)'(pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;   // channel 0 wins the first contest
         first_q <= 1'b0;
         line_q  <= 3'd0;
         oeol_q  <= 3'd0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         first_q <= first_d;
         line_q  <= line_d;
         oeol_q  <= oeol_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         if (push) tag_q[wptr_q[AW-1:0]] <= grant_d;
      end
   end

   // ---------------- protocol checkers ----------------
`ifdef DCT_ARB_ERR_EN
   logic [2:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (in_hs && !first_q) begin
         if (!grant_q && bus.s0_sof_i) err_d[0] = 1'b1;
         if ( grant_q && bus.s1_sof_i) err_d[1] = 1'b1;
      end
      if (bus.dct_valid_i && fifo_empty) err_d[2] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= 3'b000;
      else       err_q <= err_d;
   end

   assign bus.err_o = err_q;
`else
   // source sof only feeds the checkers
   logic unused_sof;
   assign unused_sof = bus.s0_sof_i ^ bus.s1_sof_i;
   assign bus.err_o  = 3'b000;
`endif

endmodule
